osc_tick_gen: RTL and testbench

- Parametrised successor to the fixed-divide on-chip oscillator wrapper.
- Takes the raw oscillator-derived clock and produces CHANNELS independent divided outputs. Each channel gives a one-cycle tick (clock enable) and a ~50% duty square wave.
- Each channel's divisor is run-time programmable and changes glitch-free.
- Feeds the CPU timing, serial baud and line-clock logic as clock enables, so no extra PLL/OSC primitives are needed.

---
 rtl/osc_tick_gen.sv | 141 ++++++++++++++
 tb/tb_osc_tick_gen.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/osc_tick_gen.sv
// Multi-channel programmable clock-enable generator driven by the oscillator clock.
// Each channel emits a one-cycle tick per period and a ~50% duty square wave.

module osc_tick_chan #(
    parameter int WIDTH     = 8,
    parameter int DIV_RESET = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             sync,
    input  logic             wr,
    input  logic [WIDTH-1:0] data,
    output logic             tick,
    output logic             clk_out,
    output logic             pending
);
    localparam logic [WIDTH-1:0] DIV_INIT = DIV_RESET[WIDTH-1:0];

    logic [WIDTH-1:0] div, cnt, pend_div;
    logic             pend_valid;

    logic [WIDTH-1:0] div_nxt, cnt_nxt, pend_div_nxt;
    logic             pend_valid_nxt, tick_nxt, clk_out_nxt;
    logic             running, wrap;
    logic [WIDTH-1:0] div_m1;

    assign running = en && (div != '0);
    // div-1 only formed for a live divisor so a halted channel never wraps to all-ones
    assign div_m1  = running ? div - 1'b1 : '0;
    assign wrap    = running && (cnt == div_m1);

    function automatic logic phase(input logic [WIDTH-1:0] c, input logic [WIDTH-1:0] d);
        return (d != '0) && (c >= (d >> 1));
    endfunction

    always_comb begin
        div_nxt        = div;
        cnt_nxt        = cnt;
        pend_div_nxt   = pend_div;
        pend_valid_nxt = pend_valid;
        tick_nxt       = 1'b0;
        clk_out_nxt    = clk_out;
        if (sync) begin
            cnt_nxt        = '0;
            pend_valid_nxt = 1'b0;
            if (pend_valid)
                div_nxt = pend_div;
            // a write landing with sync waits for the next apply point
            if (wr) begin
                pend_div_nxt   = data;
                pend_valid_nxt = 1'b1;
            end
            clk_out_nxt = phase('0, div_nxt);
        end else if (!running) begin
            if (en)
                cnt_nxt = '0;
            if (wr) begin
                div_nxt        = data;
                pend_div_nxt   = data;
                cnt_nxt        = '0;
                pend_valid_nxt = 1'b0;
            end else if (pend_valid) begin
                div_nxt        = pend_div;
                cnt_nxt        = '0;
                pend_valid_nxt = 1'b0;
            end
            if (en)
                clk_out_nxt = phase(cnt_nxt, div_nxt);
        end else begin
            if (wrap) begin
                cnt_nxt  = '0;
                tick_nxt = 1'b1;
                if (pend_valid) begin
                    div_nxt        = pend_div;
                    pend_valid_nxt = 1'b0;
                end
            end else begin
                cnt_nxt = cnt + 1'b1;
            end
            if (wr) begin
                pend_div_nxt   = data;
                pend_valid_nxt = 1'b1;
            end
            clk_out_nxt = phase(cnt_nxt, div_nxt);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div        <= DIV_INIT;
            cnt        <= '0;
            pend_div   <= '0;
            pend_valid <= 1'b0;
            tick       <= 1'b0;
            clk_out    <= 1'b0;
        end else begin
            div        <= div_nxt;
            cnt        <= cnt_nxt;
            pend_div   <= pend_div_nxt;
            pend_valid <= pend_valid_nxt;
            tick       <= tick_nxt;
            clk_out    <= clk_out_nxt;
        end
    end

    assign pending = pend_valid;
endmodule

module osc_tick_gen #(
    parameter int CHANNELS  = 2,
    parameter int WIDTH     = 8,
    parameter int DIV_RESET = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [CHANNELS-1:0] en,
    input  logic                sync,
    input  logic [CHANNELS-1:0] div_wr,
    input  logic [WIDTH-1:0]    div_data,
    output logic [CHANNELS-1:0] tick,
    output logic [CHANNELS-1:0] clk_out,
    output logic [CHANNELS-1:0] pending
);
    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
        osc_tick_chan #(
            .WIDTH     (WIDTH),
            .DIV_RESET (DIV_RESET)
        ) u_chan (
            .clk     (clk),
            .reset   (reset),
            .en      (en[i]),
            .sync    (sync),
            .wr      (div_wr[i]),
            .data    (div_data),
            .tick    (tick[i]),
            .clk_out (clk_out[i]),
            .pending (pending[i])
        );
    end
endmodule

// File: tb/tb_osc_tick_gen.sv
// Directed bench for osc_tick_gen: expected tick edges are queued per channel
// by the stimulus and a negedge monitor pops them as ticks appear.

module tb_osc_tick_gen;
    localparam int CH = 2;
    localparam int W  = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [CH-1:0] en = '0;
    logic          sync = 1'b0;
    logic [CH-1:0] div_wr = '0;
    logic [W-1:0]  div_data = '0;
    logic [CH-1:0] tick, clk_out, pending;

    int ecnt;
    int n_pass = 0;
    int n_total = 0;
    int q0[$];
    int q1[$];
    int mon_want;

    osc_tick_gen #(.CHANNELS(CH), .WIDTH(W), .DIV_RESET(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .sync     (sync),
        .div_wr   (div_wr),
        .div_data (div_data),
        .tick     (tick),
        .clk_out  (clk_out),
        .pending  (pending)
    );

    always #5 clk = ~clk;

    // edge index since reset release: edge k is the k-th rising edge out of reset
    always @(posedge clk or posedge reset) begin
        if (reset) ecnt <= 0;
        else       ecnt <= ecnt + 1;
    end

    always @(negedge clk) begin
        if (!reset) begin
            for (int c = 0; c < CH; c++) begin
                if (tick[c]) begin
                    mon_want = -1;
                    if (c == 0 && q0.size() > 0)      mon_want = q0.pop_front();
                    else if (c == 1 && q1.size() > 0) mon_want = q1.pop_front();
                    n_total++;
                    if (mon_want == ecnt) n_pass++;
                    else $display("FAIL tick%0d: fired at edge %0d, expected edge %0d (-1 = none)",
                                  c, ecnt, mon_want);
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [CH-1:0] act, input logic [CH-1:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b want %b (edge %0d)", nm, act, exp, ecnt);
    endtask

    task automatic chk_int(input string nm, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d want %0d", nm, act, exp);
    endtask

    task automatic expect_ticks(input int ch, input int first, input int period, input int n);
        for (int k = 0; k < n; k++) begin
            if (ch == 0) q0.push_back(first + k * period);
            else         q1.push_back(first + k * period);
        end
    endtask

    task automatic wait_to(input int e);
        int guard;
        guard = 0;
        while (ecnt < e) begin
            @(negedge clk);
            guard++;
            if (guard > 1000) begin
                $display("FAIL wait_to: edge %0d never reached", e);
                $fatal(1, "timeout");
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset    = 1'b1;
        en       = '0;
        div_wr   = '0;
        sync     = 1'b0;
        div_data = '0;
        repeat (2) @(negedge clk);
    endtask

    task automatic release_rst(input logic [CH-1:0] e);
        reset = 1'b0;
        en    = e;
    endtask

    task automatic scn_end(input string nm);
        repeat (3) @(negedge clk);
        chk_int({nm, "_missing_tick0"}, q0.size(), 0);
        chk_int({nm, "_missing_tick1"}, q1.size(), 0);
        q0.delete();
        q1.delete();
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_tick", tick, 2'b00);
        chk("rst_clk_out", clk_out, 2'b00);
        chk("rst_pending", pending, 2'b00);

        // defaults: both channels divide by 4
        expect_ticks(0, 4, 4, 3);
        expect_ticks(1, 4, 4, 3);
        release_rst(2'b11);
        for (int k = 1; k <= 8; k++) begin
            wait_to(k);
            chk("s1_clk_out", clk_out, (k % 4 >= 2) ? 2'b11 : 2'b00);
        end
        chk("s1_pending", pending, 2'b00);
        wait_to(12); en = '0;
        scn_end("s1");

        // ch0: write 6 mid-period, old period finishes first
        do_reset();
        q0.push_back(4);
        expect_ticks(0, 10, 6, 2);
        release_rst(2'b01);
        wait_to(1); div_data = 8'd6; div_wr = 2'b01;
        wait_to(2); div_wr = '0; chk("s2_pend_set", pending, 2'b01);
        wait_to(3); chk("s2_pend_hold", pending, 2'b01);
        wait_to(4); chk("s2_pend_clr", pending, 2'b00);
        wait_to(6); chk("s2_clk_lo", clk_out, 2'b00);
        wait_to(7); chk("s2_clk_hi", clk_out, 2'b01);
        wait_to(10); chk("s2_clk_wrap", clk_out, 2'b00);
        wait_to(16); en = '0;
        scn_end("s2");

        // ch1: halt with 0, then restart with 3
        do_reset();
        q1.push_back(4);
        expect_ticks(1, 10, 3, 3);
        release_rst(2'b10);
        wait_to(1); div_data = 8'd0; div_wr = 2'b10;
        wait_to(2); div_wr = '0; chk("s3_pend_set", pending, 2'b10);
        wait_to(5); chk("s3_halt_clk", clk_out, 2'b00); chk("s3_halt_pend", pending, 2'b00);
        wait_to(6); chk("s3_halt_clk2", clk_out, 2'b00);
        div_data = 8'd3; div_wr = 2'b10;
        wait_to(7); div_wr = '0;
        chk("s3_applied_pend", pending, 2'b00); chk("s3_clk0", clk_out, 2'b00);
        wait_to(8);  chk("s3_clk1", clk_out, 2'b10);
        wait_to(9);  chk("s3_clk2", clk_out, 2'b10);
        wait_to(10); chk("s3_clk3", clk_out, 2'b00);
        wait_to(16); en = '0;
        scn_end("s3");

        // N=3 / N=5 out of phase, sync applies pending 7 on ch0
        do_reset();
        q0.push_back(5); q0.push_back(8); q0.push_back(18); q0.push_back(25);
        q1.push_back(8); q1.push_back(16); q1.push_back(21);
        release_rst(2'b00);
        div_data = 8'd3; div_wr = 2'b01;
        wait_to(1); div_data = 8'd5; div_wr = 2'b10;
        wait_to(2); div_wr = '0; en = 2'b01;
        wait_to(3); en = 2'b11;
        wait_to(9); div_data = 8'd7; div_wr = 2'b01;
        wait_to(10); div_wr = '0; sync = 1'b1; chk("s4_pend_before_sync", pending, 2'b01);
        wait_to(11); sync = 1'b0;
        chk("s4_pend_after_sync", pending, 2'b00); chk("s4_clk_after_sync", clk_out, 2'b00);
        wait_to(25); en = '0;
        scn_end("s4");

        // write on the wrap edge, then write coincident with sync
        do_reset();
        q0.push_back(4); q0.push_back(10); q0.push_back(19); q0.push_back(28);
        q0.push_back(38); q0.push_back(40); q0.push_back(42);
        release_rst(2'b01);
        wait_to(1); div_data = 8'd6; div_wr = 2'b01;
        wait_to(2); div_wr = '0;
        wait_to(3); div_data = 8'd9; div_wr = 2'b01;
        wait_to(4); div_wr = '0; chk("s5_pend_after_wrap", pending, 2'b01);
        wait_to(10); chk("s5_pend_clr", pending, 2'b00);
        wait_to(28); div_data = 8'd2; div_wr = 2'b01; sync = 1'b1;
        wait_to(29); div_wr = '0; sync = 1'b0; chk("s5_sync_wr_pend", pending, 2'b01);
        wait_to(38); chk("s5_sync_wr_applied", pending, 2'b00);
        wait_to(42); en = '0;
        scn_end("s5");

        // async reset mid-period with a write pending
        do_reset();
        release_rst(2'b11);
        wait_to(2); div_data = 8'd5; div_wr = 2'b01;
        wait_to(3); div_wr = '0;
        chk("s6_pre_pend", pending, 2'b01); chk("s6_pre_clk", clk_out, 2'b11);
        #2 reset = 1'b1;
        #1;
        chk("s6_async_clk", clk_out, 2'b00);
        chk("s6_async_pend", pending, 2'b00);
        chk("s6_async_tick", tick, 2'b00);
        @(negedge clk);
        @(negedge clk);
        expect_ticks(0, 4, 4, 2);
        expect_ticks(1, 4, 4, 2);
        release_rst(2'b11);
        wait_to(8); en = '0;
        scn_end("s6");

        // N=1 on ch1: tick and clk_out high every cycle
        do_reset();
        expect_ticks(1, 2, 1, 8);
        release_rst(2'b00);
        div_data = 8'd1; div_wr = 2'b10;
        wait_to(1); div_wr = '0; en = 2'b10;
        for (int k = 2; k <= 9; k++) begin
            wait_to(k);
            chk("s7_n1_clk", clk_out, 2'b10);
        end
        en = '0;
        scn_end("s7");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end
endmodule
